lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter PWRUP_CYC, default 2000000, meaning idle cycles after reset before init (40 ms at 50 MHz).
REQ-002 Parameter SETUP_CYC, default 2, meaning cycles RS/data are stable before EN rises.
REQ-003 Parameter EN_CYC, default 25, meaning EN high width in cycles.
REQ-004 Parameter HOLD_CYC, default 2, meaning cycles RS/data are held after EN falls.
REQ-005 Parameter WAIT_CYC, default 2500, meaning post-write settle for normal commands/data.
REQ-006 Parameter CLR_WAIT_CYC, default 82000, meaning post-write settle for RS=0 data 0x01 or 0x02.
REQ-007 Every timing parameter SHALL be >= 1; the counter SHALL be 32-bit.
REQ-008 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-009 i_reset  in  1  reset, synchronous and active-high.
REQ-010 i_lcd_word  in  32  LSU LCD register: [31] on, [10] request toggle, [8] RS, [7:0] data; other bits ignored.
REQ-011 o_lcd_data  out  8  HD44780 DB7..DB0.
REQ-012 o_lcd_rs  out  1  register select.
REQ-013 o_lcd_rw  out  1  read/write, constant 0.
REQ-014 o_lcd_en  out  1  enable strobe.
REQ-015 o_lcd_on  out  1  panel power/backlight.
REQ-016 o_busy  out  1  high unless FSM is IDLE with no pending request.
REQ-017 o_overrun  out  1  sticky: a pending request was overwritten.

Function
REQ-018 A request SHALL be detected in any cycle where i_lcd_word[10] differs from registered last_tog; last_tog then updates to i_lcd_word[10].
REQ-019 A detected request SHALL capture {RS=[8], data=[7:0]} into a 1-deep pending slot in the same cycle.
REQ-020 Request detected while slot already full: slot overwritten with the newer value and o_overrun set; o_overrun clears only on reset.
REQ-021 o_lcd_on SHALL be i_lcd_word[31] registered one cycle, independent of FSM state.
REQ-022 FSM states: PWRUP, IDLE, SETUP, ENABLE, HOLD, WAIT.
REQ-023 PWRUP: count PWRUP_CYC cycles, then issue the init list 0x38, 0x0C, 0x01, 0x06 (RS=0), each as a full SETUP-ENABLE-HOLD-WAIT write; then IDLE.
REQ-024 Requests arriving during PWRUP/init SHALL be captured per REQ-019/020 and served after init.
REQ-025 IDLE with slot full: load slot into output regs, clear slot, enter SETUP next cycle; slot captured in the same cycle it is consumed is retained for the next write.
REQ-026 SETUP lasts SETUP_CYC cycles with en=0; ENABLE lasts EN_CYC cycles with en=1; HOLD lasts HOLD_CYC cycles with en=0; o_lcd_data/o_lcd_rs SHALL stay constant from SETUP through HOLD.
REQ-027 WAIT lasts CLR_WAIT_CYC if RS=0 and data in {0x01,0x02}, else WAIT_CYC; then IDLE.
REQ-028 A user write SHALL therefore take exactly 1+SETUP+EN+HOLD+WAIT cycles from slot capture in IDLE to return to IDLE.
REQ-029 Outputs SHALL be registered; o_lcd_en SHALL never glitch and SHALL rise only after SETUP.

Reset
REQ-030 With i_reset high at a clock edge: state=PWRUP, counter=0, init index=0, slot empty, o_overrun=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_data=0x00, o_lcd_rw=0, o_lcd_on=0, o_busy=1.
REQ-031 During reset last_tog SHALL load i_lcd_word[10], so no request is detected in the first cycle after reset.
REQ-032 Reset mid-write SHALL drop EN to 0 on that edge, abandon the write and the slot, and restart PWRUP.

Verification (PWRUP=10, SETUP=2, EN=3, HOLD=2, WAIT=5, CLR_WAIT=20)
REQ-033 Reset release, word static -> o_busy=1; EN pulses of 3 cycles carry 0x38,0x0C,0x01,0x06 with RS=0; gap after 0x01 is 20 wait cycles; o_busy=0 afterwards.
REQ-034 After init, toggle [10] with RS=1, data 0x41 -> EN high 3 cycles with data 0x41/RS=1, o_busy low exactly 13 cycles after toggle.
REQ-035 Send 0x41, then toggle twice more during its ENABLE with 0x42 then 0x43 -> 0x43 written next, 0x42 never appears, o_overrun=1.
REQ-036 Write RS=0, 0x01 -> WAIT 20 cycles; write RS=0, 0x80 -> WAIT 5 cycles.
REQ-037 Assert i_reset during ENABLE -> o_lcd_en=0 next edge, no further EN until PWRUP completes, o_overrun=0.
REQ-038 Toggle [31] at any state -> o_lcd_on follows one cycle later, FSM timing unaffected.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: power-up delay, fixed init list, then toggle-handshake
// user writes through a 1-deep pending slot with sticky overrun.
module lcd_ctrl #(
  parameter int unsigned PWRUP_CYC    = 2000000,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_CYC       = 25,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned WAIT_CYC     = 2500,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_word,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overrun
);
  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYC - 1);
  localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
  localparam logic [31:0] EN_LAST    = 32'(EN_CYC - 1);
  localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYC - 1);
  localparam logic [31:0] WAIT_LAST  = 32'(WAIT_CYC - 1);
  localparam logic [31:0] CLR_LAST   = 32'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        slot_vld_q, slot_vld_d;
  logic        slot_rs_q, slot_rs_d;
  logic [7:0]  slot_data_q, slot_data_d;
  logic        tog_q;
  logic        ovr_q, ovr_d;
  logic [7:0]  data_q, data_d;
  logic        rs_q, rs_d;
  logic        en_q, en_d;
  logic        on_q;
  logic        busy_q, busy_d;
  logic        req, take, is_clr;
  logic [7:0]  init_word;
  logic [31:0] wait_last;
  logic        unused_bits;

  assign req         = i_lcd_word[10] ^ tog_q;
  assign is_clr      = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
  assign wait_last   = is_clr ? CLR_LAST : WAIT_LAST;
  assign unused_bits = ^{i_lcd_word[30:11], i_lcd_word[9]};

  always_comb begin
    case (idx_q)
      3'd0:    init_word = 8'h38;
      3'd1:    init_word = 8'h0C;
      3'd2:    init_word = 8'h01;
      default: init_word = 8'h06;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    take    = 1'b0;
    case (state_q)
      S_PWRUP: if (cnt_q == PWRUP_LAST) begin
        state_d = S_SETUP;
        cnt_d   = '0;
        data_d  = init_word;
        rs_d    = 1'b0;
        idx_d   = idx_q + 3'd1;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (slot_vld_q) begin
          take    = 1'b1;
          data_d  = slot_data_q;
          rs_d    = slot_rs_q;
          state_d = S_SETUP;
        end
      end
      S_SETUP:  if (cnt_q == SETUP_LAST) begin state_d = S_ENABLE; cnt_d = '0; end
      S_ENABLE: if (cnt_q == EN_LAST)    begin state_d = S_HOLD;   cnt_d = '0; end
      S_HOLD:   if (cnt_q == HOLD_LAST)  begin state_d = S_WAIT;   cnt_d = '0; end
      S_WAIT: if (cnt_q == wait_last) begin
        cnt_d = '0;
        // Init list chains straight into the next write; user writes go back to IDLE.
        if (idx_q < 3'd4) begin
          state_d = S_SETUP;
          data_d  = init_word;
          rs_d    = 1'b0;
          idx_d   = idx_q + 3'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin state_d = S_PWRUP; cnt_d = '0; end
    endcase

    // A request landing on the consume edge refills the freed slot, no overrun.
    slot_vld_d  = slot_vld_q & ~take;
    slot_rs_d   = slot_rs_q;
    slot_data_d = slot_data_q;
    ovr_d       = ovr_q;
    if (req) begin
      if (slot_vld_d) ovr_d = 1'b1;
      slot_vld_d  = 1'b1;
      slot_rs_d   = i_lcd_word[8];
      slot_data_d = i_lcd_word[7:0];
    end

    en_d   = (state_d == S_ENABLE);
    busy_d = !(state_d == S_IDLE && !slot_vld_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      slot_vld_q  <= 1'b0;
      slot_rs_q   <= 1'b0;
      slot_data_q <= '0;
      tog_q       <= i_lcd_word[10];
      ovr_q       <= 1'b0;
      data_q      <= '0;
      rs_q        <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      slot_vld_q  <= slot_vld_d;
      slot_rs_q   <= slot_rs_d;
      slot_data_q <= slot_data_d;
      tog_q       <= i_lcd_word[10];
      ovr_q       <= ovr_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      en_q        <= en_d;
      on_q        <= i_lcd_word[31];
      busy_q      <= busy_d;
    end
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_busy     = busy_q;
  assign o_overrun  = ovr_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// Randomized bench for lcd_ctrl: an event-level model predicts which bytes are
// written and when each EN pulse starts; a negedge monitor records actual pulses.
module tb_lcd_ctrl;
  localparam int P_PWRUP = 10;
  localparam int P_SETUP = 2;
  localparam int P_EN    = 3;
  localparam int P_HOLD  = 2;
  localparam int P_WAIT  = 5;
  localparam int P_CLR   = 20;

  logic        clk, rst;
  logic [31:0] word;
  logic [7:0]  data;
  logic        rs, rw, en, on, busy, ovr;

  lcd_ctrl #(
    .PWRUP_CYC(P_PWRUP), .SETUP_CYC(P_SETUP), .EN_CYC(P_EN),
    .HOLD_CYC(P_HOLD), .WAIT_CYC(P_WAIT), .CLR_WAIT_CYC(P_CLR)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_lcd_word(word),
    .o_lcd_data(data), .o_lcd_rs(rs), .o_lcd_rw(rw), .o_lcd_en(en),
    .o_lcd_on(on), .o_busy(busy), .o_overrun(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; logic rs; int rise; int w; } pulse_t;

  int checks = 0;
  int errors = 0;

  // ---------------- monitor ----------------
  pulse_t     obs_q[$];
  pulse_t     cur;
  bit         in_p = 0;
  int         hold_n = 0;
  logic [7:0] prev_d = '0;
  logic       prev_rs = 1'b0;
  logic       prev_busy = 1'b1;
  int         busy_fall = -1;
  int         busy_falls = 0;
  int         stab_err = 0, on_err = 0, rw_err = 0;

  always @(negedge clk) begin
    if (rw !== 1'b0) rw_err++;
    if (on !== (rst ? 1'b0 : word[31])) on_err++;
    if (rst) begin
      in_p   = 0;
      hold_n = 0;
    end else if (en === 1'b1) begin
      if (!in_p) begin
        in_p = 1;
        cur.d = data; cur.rs = rs; cur.rise = cyc; cur.w = 0;
        if (data !== prev_d || rs !== prev_rs) stab_err++;
      end
      cur.w++;
      if (data !== cur.d || rs !== cur.rs) stab_err++;
    end else begin
      if (in_p) begin
        in_p = 0;
        obs_q.push_back(cur);
        hold_n = P_HOLD;
      end
      if (hold_n > 0) begin
        hold_n--;
        if (data !== cur.d || rs !== cur.rs) stab_err++;
      end
    end
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      busy_fall = cyc;
      busy_falls++;
    end
    prev_busy = busy; prev_d = data; prev_rs = rs;
  end

  // ---------------- reference model ----------------
  // Times are edge indices (value of cyc right after that posedge).
  pulse_t     exp_q[$];
  int         m_free;
  bit         m_pv, m_ovr, m_prs;
  int         m_pt;
  logic [7:0] m_pd;
  logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int wlen(logic r, logic [7:0] d);
    return (!r && (d == 8'h01 || d == 8'h02)) ? P_CLR : P_WAIT;
  endfunction

  function automatic void m_write(int load, logic r, logic [7:0] d);
    pulse_t p;
    p.d = d; p.rs = r; p.rise = load + P_SETUP; p.w = P_EN;
    exp_q.push_back(p);
    m_free = load + P_SETUP + P_EN + P_HOLD + wlen(r, d);
  endfunction

  function automatic void m_init(int r);
    int load;
    exp_q.delete(); m_pv = 0; m_ovr = 0;
    load = r + P_PWRUP;
    for (int i = 0; i < 4; i++) begin
      m_write(load, 1'b0, init_seq[i]);
      load = m_free;
    end
  endfunction

  function automatic int m_load_edge();
    return ((m_free > m_pt) ? m_free : m_pt) + 1;
  endfunction

  function automatic void m_flush();
    if (m_pv) begin
      m_write(m_load_edge(), m_prs, m_pd);
      m_pv = 0;
    end
  endfunction

  function automatic void m_req(int t, logic r, logic [7:0] d);
    if (m_pv && m_load_edge() <= t) m_flush();
    if (m_pv) m_ovr = 1;
    m_pv = 1; m_pt = t; m_prs = r; m_pd = d;
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic r, input logic [7:0] d, output int t);
    @(negedge clk); #1;
    word[30:11] = 20'($urandom);
    word[9]     = 1'($urandom);
    word[10]    = ~word[10];
    word[8]     = r;
    word[7:0]   = d;
    t = cyc + 1;
    m_req(t, r, d);
  endtask

  task automatic rst_release(output int r);
    @(negedge clk); #1;
    rst = 1'b0;
    r = cyc;
    obs_q.delete();
    busy_falls = 0;
    m_init(r);
  endtask

  task automatic wait_model_idle();
    m_flush();
    while (cyc < m_free + 3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  int r_edge;

  task automatic test_reset();
    word = 32'h8000_0000 | 32'($urandom_range(0, 255));
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({data, rs, en, rw, on, busy, ovr} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got data=%h rs=%b en=%b rw=%b on=%b busy=%b ovr=%b exp 00 0 0 0 0 1 0",
               data, rs, en, rw, on, busy, ovr);
    end
    #1 word[10] = ~word[10];
    @(negedge clk);
    rst_release(r_edge);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_after got %b exp 1", busy); end
    checks++;
    if (on !== 1'b1) begin errors++; $display("FAIL reset_on_follow got %b exp 1", on); end
  endtask

  task automatic test_init();
    wait_model_idle();
    checks++;
    if (obs_q.size() != 4) begin errors++; $display("FAIL init_count got %0d exp 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].rs !== 1'b0 || obs_q[i].rise != exp_q[i].rise || obs_q[i].w != P_EN) begin
        errors++;
        $display("FAIL init_pulse%0d got d=%h rs=%b rise=%0d w=%0d exp d=%h rs=0 rise=%0d w=%0d",
                 i, obs_q[i].d, obs_q[i].rs, obs_q[i].rise, obs_q[i].w, exp_q[i].d, exp_q[i].rise, P_EN);
      end
    end
    if (obs_q.size() == 4) begin
      checks++;
      if (obs_q[3].rise - (obs_q[2].rise + P_EN) != P_HOLD + P_CLR + P_SETUP) begin
        errors++;
        $display("FAIL init_clr_gap got %0d exp %0d", obs_q[3].rise - (obs_q[2].rise + P_EN), P_HOLD + P_CLR + P_SETUP);
      end
    end
    checks++;
    if (busy_falls != 1 || busy_fall != m_free || busy !== 1'b0) begin
      errors++;
      $display("FAIL init_busy got falls=%0d at=%0d busy=%b exp falls=1 at=%0d busy=0", busy_falls, busy_fall, busy, m_free);
    end
  endtask

  task automatic test_single();
    int t;
    obs_q.delete(); exp_q.delete(); busy_falls = 0;
    send(1'b1, 8'h41, t);
    wait_model_idle();
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL single_count got %0d exp 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0].d !== 8'h41 || obs_q[0].rs !== 1'b1 || obs_q[0].rise != t + 1 + P_SETUP || obs_q[0].w != P_EN) begin
        errors++;
        $display("FAIL single_pulse got d=%h rs=%b rise=%0d w=%0d exp d=41 rs=1 rise=%0d w=%0d",
                 obs_q[0].d, obs_q[0].rs, obs_q[0].rise, obs_q[0].w, t + 1 + P_SETUP, P_EN);
      end
    end
    checks++;
    if (busy_falls != 1 || busy_fall - t != 1 + P_SETUP + P_EN + P_HOLD + P_WAIT) begin
      errors++;
      $display("FAIL single_busy_latency got %0d (falls=%0d) exp %0d", busy_fall - t, busy_falls,
               1 + P_SETUP + P_EN + P_HOLD + P_WAIT);
    end
  endtask

  task automatic test_clr_wait();
    int t1, t2;
    obs_q.delete(); exp_q.delete(); busy_falls = 0;
    send(1'b0, 8'h01, t1);
    wait_model_idle();
    checks++;
    if (busy_fall - t1 != 1 + P_SETUP + P_EN + P_HOLD + P_CLR || obs_q.size() != 1) begin
      errors++;
      $display("FAIL clr_wait_len got %0d pulses=%0d exp %0d pulses=1", busy_fall - t1, obs_q.size(),
               1 + P_SETUP + P_EN + P_HOLD + P_CLR);
    end
    send(1'b0, 8'h80, t2);
    wait_model_idle();
    checks++;
    if (busy_fall - t2 != 1 + P_SETUP + P_EN + P_HOLD + P_WAIT || obs_q.size() != 2) begin
      errors++;
      $display("FAIL norm_wait_len got %0d pulses=%0d exp %0d pulses=2", busy_fall - t2, obs_q.size(),
               1 + P_SETUP + P_EN + P_HOLD + P_WAIT);
    end else begin
      checks++;
      if (obs_q[1].d !== 8'h80 || obs_q[1].rs !== 1'b0) begin
        errors++; $display("FAIL norm_wait_data got d=%h rs=%b exp d=80 rs=0", obs_q[1].d, obs_q[1].rs);
      end
    end
  endtask

  task automatic test_random();
    int t, gap;
    logic r;
    logic [7:0] d;
    obs_q.delete(); exp_q.delete(); busy_falls = 0;
    stab_err = 0; on_err = 0; rw_err = 0;
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 16);
      repeat (gap) begin
        @(negedge clk); #1;
        if ($urandom_range(0, 3) == 0) word[31] = ~word[31];
      end
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin r = 1'b0; d = 8'($urandom_range(1, 2)); end
      send(r, d, t);
    end
    wait_model_idle();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].rs !== exp_q[i].rs || obs_q[i].rise != exp_q[i].rise || obs_q[i].w != P_EN) begin
        errors++;
        $display("FAIL rand_pulse%0d got d=%h rs=%b rise=%0d w=%0d exp d=%h rs=%b rise=%0d w=%0d",
                 i, obs_q[i].d, obs_q[i].rs, obs_q[i].rise, obs_q[i].w, exp_q[i].d, exp_q[i].rs, exp_q[i].rise, P_EN);
      end
    end
    checks++;
    if (ovr !== m_ovr) begin errors++; $display("FAIL rand_overrun got %b exp %b", ovr, m_ovr); end
    checks++;
    if (busy_fall != m_free || busy !== 1'b0) begin
      errors++; $display("FAIL rand_busy got fall=%0d busy=%b exp fall=%0d busy=0", busy_fall, busy, m_free);
    end
    checks++;
    if (stab_err != 0 || on_err != 0 || rw_err != 0) begin
      errors++; $display("FAIL rand_monitor got stab=%0d on=%0d rw=%0d exp 0 0 0", stab_err, on_err, rw_err);
    end
  endtask

  task automatic test_reset_mid();
    int t, k;
    send(1'b1, 8'h55, t);
    send(1'b1, 8'h66, t);
    send(1'b1, 8'h77, t);
    k = 0;
    while (en !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (en !== 1'b1 || ovr !== 1'b1) begin
      errors++; $display("FAIL mid_setup got en=%b ovr=%b exp en=1 ovr=1", en, ovr);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (en !== 1'b0 || ovr !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset_edge got en=%b ovr=%b busy=%b exp 0 0 1", en, ovr, busy);
    end
    rst_release(r_edge);
    repeat (3) @(negedge clk);
    send(1'b1, 8'h4A, t);
    wait_model_idle();
    checks++;
    if (obs_q.size() != 5) begin errors++; $display("FAIL mid_count got %0d exp 5", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].d !== exp_q[i].d || obs_q[i].rs !== exp_q[i].rs || obs_q[i].rise != exp_q[i].rise) begin
        errors++;
        $display("FAIL mid_pulse%0d got d=%h rs=%b rise=%0d exp d=%h rs=%b rise=%0d",
                 i, obs_q[i].d, obs_q[i].rs, obs_q[i].rise, exp_q[i].d, exp_q[i].rs, exp_q[i].rise);
      end
    end
    checks++;
    if (ovr !== 1'b0) begin errors++; $display("FAIL mid_overrun_clear got %b exp 0", ovr); end
  endtask

  task automatic test_overrun();
    int t, k;
    bit seen42;
    obs_q.delete(); exp_q.delete(); busy_falls = 0;
    send(1'b1, 8'h41, t);
    k = 0;
    while (en !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL ovr_en_wait got en=%b exp 1", en); end
    send(1'b1, 8'h42, t);
    send(1'b1, 8'h43, t);
    wait_model_idle();
    seen42 = 0;
    foreach (obs_q[i]) if (obs_q[i].d === 8'h42) seen42 = 1;
    checks++;
    if (obs_q.size() != 2 || seen42) begin
      errors++; $display("FAIL ovr_count got %0d seen42=%0d exp 2 seen42=0", obs_q.size(), seen42);
    end else begin
      checks++;
      if (obs_q[0].d !== 8'h41 || obs_q[1].d !== 8'h43 || obs_q[1].rise != exp_q[1].rise) begin
        errors++;
        $display("FAIL ovr_order got %h,%h rise=%0d exp 41,43 rise=%0d", obs_q[0].d, obs_q[1].d, obs_q[1].rise, exp_q[1].rise);
      end
    end
    checks++;
    if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", ovr); end
  endtask

  initial begin
    rst  = 1'b1;
    word = '0;
    test_reset();
    test_init();
    test_single();
    test_clr_wait();
    test_random();
    test_reset_mid();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
